mb_audio_sampler: RTL

Downstream stage of the Mockingboard. Consumes the two unsigned 10-bit PSG mix buses (audio_l/audio_r, range 0..765), which update at PHI1 rate, and box-car decimates them by 2^DECIM_LOG2. It then removes the DC offset, scales and saturates the result to signed 16-bit stereo PCM, and presents it on a valid/ready interface. The consumer is the platform audio mixer / I2S serializer.

---
 rtl/mb_audio_sampler_if.sv | 18 +
 rtl/mb_audio_sampler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mb_audio_sampler_if.sv
// PCM output channel from the Mockingboard sampler to the platform audio mixer.
// The sampler drives the master side and the consumer drives the slave side.
interface mb_audio_sampler_if;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic [15:0] sample_l_o;
    logic [15:0] sample_r_o;

    modport master (
        output sample_valid_o, sample_l_o, sample_r_o,
        input  sample_ready_i
    );

    modport slave (
        input  sample_valid_o, sample_l_o, sample_r_o,
        output sample_ready_i
    );
endinterface

// File: rtl/mb_audio_sampler.sv
// Box-car decimates the stereo PSG mix, centres, scales and saturates it to signed 16-bit PCM.
// Optional DC tracking on the centre reference: define MB_AUDIO_DC_BLOCK_EN.
module mb_audio_sampler #(
    parameter int DECIM_LOG2 = 5,
    parameter int MIDPOINT   = 383,
    parameter int GAIN_SHIFT = 5,
    parameter int DC_SHIFT   = 10
) (
    input  logic                 clk_logic,
    input  logic                 system_reset_n,
    input  logic                 sample_en_i,
    input  logic                 enable_i,
    input  logic [9:0]           audio_l_i,
    input  logic [9:0]           audio_r_i,
    mb_audio_sampler_if.master   pcm,
    output logic                 overrun_o,
    input  logic                 overrun_clr_i
);
    localparam int ACC_W = 10 + DECIM_LOG2;
    localparam int DC_W  = 10 + DC_SHIFT;
    localparam logic [DECIM_LOG2-1:0] CNT_MAX = '1;
    localparam logic [9:0] MID10 = 10'(MIDPOINT);

    if (GAIN_SHIFT < 0 || GAIN_SHIFT > 8 || DC_SHIFT < 1) begin : g_bad_param
        $error("mb_audio_sampler: GAIN_SHIFT must be 0..8 and DC_SHIFT >= 1");
    end

    typedef enum logic [1:0] {IDLE, CENTER, SCALE} state_t;

    state_t                  state_q, state_d;
    logic [DECIM_LOG2-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]        acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [ACC_W-1:0]        sum_l, sum_r;
    logic [9:0]              avg_l_q, avg_l_d, avg_r_q, avg_r_d;
    logic [9:0]              ref_l, ref_r;
    logic signed [10:0]      diff_l_q, diff_l_d, diff_r_q, diff_r_d;
    logic signed [10:0]      ctr_l, ctr_r;
    logic [15:0]             out_l_q, out_l_d, out_r_q, out_r_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    start, load_diff, load_out, overrun_set;

    function automatic logic [15:0] sat16(input logic signed [10:0] d);
        logic signed [19:0] w;
        w = {{9{d[10]}}, d};
        w = w <<< GAIN_SHIFT;
        if (w > 20'sd32767)       sat16 = 16'h7FFF;
        else if (w < -20'sd32768) sat16 = 16'h8000;
        else                      sat16 = w[15:0];
    endfunction

`ifdef MB_AUDIO_DC_BLOCK_EN
    logic [DC_W-1:0] dc_l_q, dc_l_d, dc_r_q, dc_r_d;
    localparam logic [DC_W-1:0] DC_INIT = DC_W'(MIDPOINT) << DC_SHIFT;

    assign ref_l = dc_l_q[DC_W-1:DC_SHIFT];
    assign ref_r = dc_r_q[DC_W-1:DC_SHIFT];

    // The estimate chases the centred sample, so a constant input decays toward zero output.
    always_comb begin
        dc_l_d = dc_l_q;
        dc_r_d = dc_r_q;
        if (load_diff) begin
            dc_l_d = dc_l_q + {{(DC_W-11){ctr_l[10]}}, ctr_l};
            dc_r_d = dc_r_q + {{(DC_W-11){ctr_r[10]}}, ctr_r};
        end
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            dc_l_q <= DC_INIT;
            dc_r_q <= DC_INIT;
        end else begin
            dc_l_q <= dc_l_d;
            dc_r_q <= dc_r_d;
        end
    end
`else
    assign ref_l = MID10;
    assign ref_r = MID10;
`endif

    assign start = sample_en_i & enable_i & (cnt_q == CNT_MAX);
    assign sum_l = acc_l_q + ACC_W'(audio_l_i);
    assign sum_r = acc_r_q + ACC_W'(audio_r_i);
    assign ctr_l = $signed({1'b0, avg_l_q}) - $signed({1'b0, ref_l});
    assign ctr_r = $signed({1'b0, avg_r_q}) - $signed({1'b0, ref_r});

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) state_q <= IDLE;
        else                 state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CENTER;
            CENTER:  state_d = SCALE;
            SCALE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_diff = (state_q == CENTER);
        load_out  = (state_q == SCALE);
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_l_d  = acc_l_q;
        acc_r_d  = acc_r_q;
        avg_l_d  = avg_l_q;
        avg_r_d  = avg_r_q;
        diff_l_d = diff_l_q;
        diff_r_d = diff_r_q;
        out_l_d  = out_l_q;
        out_r_d  = out_r_q;
        if (!enable_i) begin
            cnt_d   = '0;
            acc_l_d = '0;
            acc_r_d = '0;
        end else if (sample_en_i) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_MAX) begin
                acc_l_d = '0;
                acc_r_d = '0;
                avg_l_d = sum_l[ACC_W-1:DECIM_LOG2];
                avg_r_d = sum_r[ACC_W-1:DECIM_LOG2];
            end else begin
                acc_l_d = sum_l;
                acc_r_d = sum_r;
            end
        end
        if (load_diff) begin
            diff_l_d = ctr_l;
            diff_r_d = ctr_r;
        end
        if (load_out) begin
            out_l_d = sat16(diff_l_q);
            out_r_d = sat16(diff_r_q);
        end
        // A fresh load always wins over a same-cycle accept.
        if (load_out)                valid_d = 1'b1;
        else if (pcm.sample_ready_i) valid_d = 1'b0;
        else                         valid_d = valid_q;
        overrun_set = load_out & valid_q & ~pcm.sample_ready_i;
        overrun_d   = overrun_set | (overrun_q & ~overrun_clr_i);
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            cnt_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            avg_l_q   <= '0;
            avg_r_q   <= '0;
            diff_l_q  <= '0;
            diff_r_q  <= '0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            avg_l_q   <= avg_l_d;
            avg_r_q   <= avg_r_d;
            diff_l_q  <= diff_l_d;
            diff_r_q  <= diff_r_d;
            out_l_q   <= out_l_d;
            out_r_q   <= out_r_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign pcm.sample_valid_o = valid_q;
    assign pcm.sample_l_o     = out_l_q;
    assign pcm.sample_r_o     = out_r_q;
    assign overrun_o          = overrun_q;
endmodule
